// File: rtl/uart_cmd_responder_pkg.sv
// Shared types and constants for the remote command link: RX byte-assembly
// states, default inter-byte timeout and the UART baud settings.
package uart_cmd_responder_pkg;

  typedef enum logic {
    HIGH_WAIT = 1'b0,
    LOW_WAIT  = 1'b1
  } rx_state_t;

  localparam int DEFAULT_TIMEOUT_CYC = 100000;

  localparam int CLK_HZ           = 50_000_000;
  localparam int BAUD_RATE        = 115_200;
  localparam int DEFAULT_BAUD_DIV = CLK_HZ / BAUD_RATE;
  localparam int UART_FRAME_BITS  = 10;

endpackage

// File: rtl/uart_cmd_responder_uart.sv
// 8N1 UART transceiver: one-shot transmit with a tx_done pulse, and a receiver
// that holds rx_rdy until the consumer clears it.
module UART
  import uart_cmd_responder_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy
);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(UART_FRAME_BITS - 1);

  logic [9:0]  r_tx_shift;
  logic [15:0] r_tx_baud;
  logic [3:0]  r_tx_bits;
  logic        r_tx_busy;
  logic        r_tx_done;
  logic        r_rx_meta;
  logic        r_rx_sync;
  logic [15:0] r_rx_baud;
  logic [3:0]  r_rx_bits;
  logic [7:0]  r_rx_shift;
  logic        r_rx_busy;
  logic [7:0]  r_rx_data;
  logic        r_rx_rdy;

  // Idle line is all ones in the shift register, so TX is always a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= 10'h3FF;
      r_tx_baud  <= 16'd0;
      r_tx_bits  <= 4'd0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (!r_tx_busy) begin
        if (trmt) begin
          r_tx_shift <= {1'b1, tx_data, 1'b0};
          r_tx_baud  <= 16'd0;
          r_tx_bits  <= 4'd0;
          r_tx_busy  <= 1'b1;
        end
      end else if (r_tx_baud == BAUD_LAST) begin
        r_tx_baud  <= 16'd0;
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        if (r_tx_bits == LAST_BIT) begin
          r_tx_busy <= 1'b0;
          r_tx_done <= 1'b1;
        end else begin
          r_tx_bits <= r_tx_bits + 4'd1;
        end
      end else begin
        r_tx_baud <= r_tx_baud + 16'd1;
      end
    end
  end

  // Receiver: synchronise RX, then sample each bit near its centre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_baud  <= 16'd0;
      r_rx_bits  <= 4'd0;
      r_rx_shift <= 8'h00;
      r_rx_busy  <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_rdy   <= 1'b0;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      if (clr_rx_rdy) begin
        r_rx_rdy <= 1'b0;
      end
      if (!r_rx_busy) begin
        if (!r_rx_sync) begin
          r_rx_busy <= 1'b1;
          r_rx_baud <= BAUD_HALF;
          r_rx_bits <= 4'd0;
        end
      end else if (r_rx_baud == 16'd0) begin
        r_rx_baud <= BAUD_LAST;
        if (r_rx_bits == 4'd0) begin
          if (r_rx_sync) begin
            r_rx_busy <= 1'b0;
          end else begin
            r_rx_bits <= 4'd1;
          end
        end else if (r_rx_bits == LAST_BIT) begin
          r_rx_busy <= 1'b0;
          r_rx_data <= r_rx_shift;
          r_rx_rdy  <= 1'b1;
        end else begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_rx_bits  <= r_rx_bits + 4'd1;
        end
      end else begin
        r_rx_baud <= r_rx_baud - 16'd1;
      end
    end
  end

  assign TX      = r_tx_shift[0];
  assign tx_done = r_tx_done;
  assign rx_data = r_rx_data;
  assign rx_rdy  = r_rx_rdy;

endmodule

// File: rtl/uart_cmd_responder.sv
// Device end of the remote command link: assembles two UART bytes into a
// 16-bit command with an inter-byte timeout, and sends one response byte.
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int BAUD_DIV    = DEFAULT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        rx_err
);
  localparam int               CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [7:0]       r_high_byte;
  logic [CNT_W-1:0] r_to_cnt;
  logic [15:0]      r_cmd;
  logic             r_cmd_rdy;
  logic             r_busy;
  logic             r_resp_sent;
  logic             r_rx_err;
  logic [7:0]       w_rx_data;
  logic             w_rx_rdy;
  logic             w_clr_rx_rdy;
  logic             w_tx_done;
  logic             w_trmt;
  logic             w_cap_high;
  logic             w_cmd_done;
  logic             w_timeout;

  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .tx_data    (resp),
    .trmt       (w_trmt),
    .tx_done    (w_tx_done),
    .rx_data    (w_rx_data),
    .rx_rdy     (w_rx_rdy),
    .clr_rx_rdy (w_clr_rx_rdy)
  );

  assign w_trmt = send_resp & ~r_busy;

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HIGH_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Byte-assembly next state; rx_rdy takes priority over the timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_clr_rx_rdy = 1'b0;
    w_cap_high   = 1'b0;
    w_cmd_done   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      HIGH_WAIT: begin
        if (w_rx_rdy) begin
          w_cap_high   = 1'b1;
          w_clr_rx_rdy = 1'b1;
          w_state_nxt  = LOW_WAIT;
        end else begin
          w_state_nxt = HIGH_WAIT;
        end
      end
      LOW_WAIT: begin
        if (w_rx_rdy) begin
          w_cmd_done   = 1'b1;
          w_clr_rx_rdy = 1'b1;
          w_state_nxt  = HIGH_WAIT;
        end else if (r_to_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = HIGH_WAIT;
        end else begin
          w_state_nxt = LOW_WAIT;
        end
      end
      default: begin
        w_state_nxt = HIGH_WAIT;
      end
    endcase
  end

  // Command datapath, timeout counter and the sticky cmd_rdy flag (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_byte <= 8'h00;
      r_to_cnt    <= '0;
      r_cmd       <= 16'h0000;
      r_cmd_rdy   <= 1'b0;
      r_rx_err    <= 1'b0;
    end else begin
      if (w_cap_high) begin
        r_high_byte <= w_rx_data;
      end else if (w_timeout) begin
        r_high_byte <= 8'h00;
      end
      if (w_cap_high || w_cmd_done || w_timeout) begin
        r_to_cnt <= '0;
      end else if (r_state == LOW_WAIT) begin
        r_to_cnt <= r_to_cnt + CNT_W'(1);
      end
      if (w_cmd_done) begin
        r_cmd <= {r_high_byte, w_rx_data};
      end
      if (w_cmd_done) begin
        r_cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
      r_rx_err <= w_timeout;
    end
  end

  // Response path: busy covers one frame, resp_sent marks its completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_resp_sent <= 1'b0;
    end else if (w_tx_done) begin
      r_busy      <= 1'b0;
      r_resp_sent <= 1'b1;
    end else if (w_trmt) begin
      r_busy      <= 1'b1;
      r_resp_sent <= 1'b0;
    end
  end

  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign resp_sent = r_resp_sent;
  assign rx_err    = r_rx_err;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: byte assembly, timeout recovery,
// flag priorities, response framing and mid-operation reset.
module tb_uart_cmd_responder;
  import uart_cmd_responder_pkg::*;

  localparam int BIT_CYC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        rx_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   err_cnt = 0;
  int   tx_low  = 0;
  bit   mon_en  = 1'b0;
  bit   tx_mon_en = 1'b0;
  bit   drop_seen = 1'b0;
  bit   ok;
  int   delay;
  logic [9:0] cap;

  uart_cmd_responder #(.TIMEOUT_CYC(1000), .BAUD_DIV(BIT_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .rx_err      (rx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_err) err_cnt <= err_cnt + 1;
  always @(posedge clk) if (mon_en && !cmd_rdy) drop_seen <= 1'b1;
  always @(posedge clk) if (tx_mon_en && !TX) tx_low <= tx_low + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      RX = frame[k];
      step(BIT_CYC);
    end
  endtask

  task automatic wait_rx_rdy(output bit found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (dut.w_rx_rdy) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_resp_sent(output bit found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (resp_sent) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
    step(3);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", cmd_rdy, 1'b0);
    check("rst_resp_sent", resp_sent, 1'b0);
    check("rst_rx_err", rx_err, 1'b0);
    check("rst_tx", TX, 1'b1);
    rst_n = 1'b1;
    step(5);

    // A5 then 5A: cmd_rdy one cycle after the low byte's rx_rdy
    send_byte(8'hA5);
    fork
      send_byte(8'h5A);
      begin
        wait_rx_rdy(ok);
        check("t1_rx_seen", ok, 1'b1);
        check("t1_rdy_before", cmd_rdy, 1'b0);
        step(1);
        check("t1_rdy_after", cmd_rdy, 1'b1);
        check("t1_cmd", cmd, 16'hA55A);
      end
    join
    clr_cmd_rdy = 1'b1;
    step(1);
    clr_cmd_rdy = 1'b0;
    check("t1_rdy_cleared", cmd_rdy, 1'b0);
    check("t1_cmd_held", cmd, 16'hA55A);

    // lone high byte times out 1001 cycles after its rx_rdy is seen
    fork
      send_byte(8'h12);
      begin
        wait_rx_rdy(ok);
        check("t3_rx_seen", ok, 1'b1);
        delay = 0;
        for (int i = 1; i <= 1500; i++) begin
          step(1);
          if (rx_err) begin
            delay = i;
            break;
          end
        end
        check("t3_err_delay", delay, 1001);
        step(1);
        check("t3_err_one_cycle", rx_err, 1'b0);
      end
    join
    check("t3_no_rdy", cmd_rdy, 1'b0);
    check("t3_cmd_unchanged", cmd, 16'hA55A);
    step(200);
    send_byte(8'h34);
    send_byte(8'h56);
    step(2);
    check("t3_cmd", cmd, 16'h3456);
    check("t3_rdy", cmd_rdy, 1'b1);
    check("t3_err_count", err_cnt, 1);

    // back-to-back commands, clear coincident with second completion
    clr_cmd_rdy = 1'b1;
    step(1);
    clr_cmd_rdy = 1'b0;
    send_byte(8'h11);
    send_byte(8'h11);
    step(2);
    check("t4_rdy_first", cmd_rdy, 1'b1);
    check("t4_cmd_first", cmd, 16'h1111);
    mon_en = 1'b1;
    send_byte(8'h22);
    fork
      send_byte(8'h22);
      begin
        wait_rx_rdy(ok);
        clr_cmd_rdy = 1'b1;
        step(1);
        clr_cmd_rdy = 1'b0;
        check("t4_set_wins", cmd_rdy, 1'b1);
        check("t4_cmd_second", cmd, 16'h2222);
      end
    join
    step(2);
    mon_en = 1'b0;
    check("t4_rdy_never_dropped", drop_seen, 1'b0);

    // response C3: sample each bit at its centre
    resp = 8'hC3;
    send_resp = 1'b1;
    step(1);
    send_resp = 1'b0;
    resp = 8'h00;
    step(8);
    cap[0] = TX;
    for (int k = 1; k < 10; k++) begin
      step(BIT_CYC);
      cap[k] = TX;
    end
    check("t5_frame", cap, {1'b1, 8'hC3, 1'b0});
    check("t5_sent_during", resp_sent, 1'b0);
    wait_resp_sent(ok);
    check("t5_sent_set", ok, 1'b1);
    check("t5_tx_idle", TX, 1'b1);

    // second frame 3C with an ignored send_resp mid-frame: 5 low bits total
    tx_mon_en = 1'b1;
    resp = 8'h3C;
    send_resp = 1'b1;
    step(1);
    send_resp = 1'b0;
    check("t5_sent_cleared", resp_sent, 1'b0);
    step(50);
    resp = 8'hFF;
    send_resp = 1'b1;
    step(1);
    send_resp = 1'b0;
    wait_resp_sent(ok);
    check("t5_sent_set2", ok, 1'b1);
    step(300);
    tx_mon_en = 1'b0;
    check("t5_tx_low_cycles", tx_low, 5 * BIT_CYC);

    // reset after high byte FF with a TX frame in flight
    send_byte(8'hFF);
    resp = 8'h00;
    send_resp = 1'b1;
    step(1);
    send_resp = 1'b0;
    step(20);
    check("t6_tx_busy", TX, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx", TX, 1'b1);
    check("t6_rst_cmd", cmd, 16'h0000);
    check("t6_rst_cmd_rdy", cmd_rdy, 1'b0);
    check("t6_rst_resp_sent", resp_sent, 1'b0);
    check("t6_rst_rx_err", rx_err, 1'b0);
    check("t6_rst_state", dut.r_state, HIGH_WAIT);
    step(3);
    rst_n = 1'b1;
    step(5);
    send_byte(8'h00);
    send_byte(8'h01);
    step(2);
    check("t6_cmd_aligned", cmd, 16'h0001);
    check("t6_rdy", cmd_rdy, 1'b1);
    check("t6_tx_idle", TX, 1'b1);
    check("t6_err_count", err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Device-side end of the remote command link. Receives a 16-bit command as two UART bytes (high byte first, then low byte) and presents it as one registered word with a sticky ready flag.
- Returns an 8-bit response byte over the same UART.
- Sits between the serial pins and the device's command processor.
- Includes an inter-byte timeout so a lost byte cannot leave the link permanently out of byte alignment.

Parameters:
- TIMEOUT_CYC, default 100000: clock cycles allowed between the high byte's rx_rdy and the low byte's rx_rdy before the partial command is discarded. Minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- RX  input  1  serial data in from the host
- TX  output  1  serial data out to the host
- cmd  output  16  last fully received command, {high byte, low byte}
- cmd_rdy  output  1  sticky flag: a new command is available
- clr_cmd_rdy  input  1  one-cycle pulse from the consumer to clear cmd_rdy
- resp  input  8  response byte to transmit
- send_resp  input  1  one-cycle pulse to start transmitting resp
- resp_sent  output  1  sticky flag: response transmission is complete
- rx_err  output  1  one-cycle pulse when a partial command is discarded on timeout

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: cmd=16'h0000, cmd_rdy=0, resp_sent=0, rx_err=0, TX=1 (idle line, driven by the UART), RX state=HIGH_WAIT, timeout counter=0, busy=0.

RX state machine (states HIGH_WAIT, LOW_WAIT):
- HIGH_WAIT, UART rx_rdy=1:
  - Capture rx_data into high_byte.
  - Pulse clr_rx_rdy for one cycle.
  - Clear the timeout counter.
  - Go to LOW_WAIT.
- LOW_WAIT, rx_rdy=1:
  - Register cmd <= {high_byte, rx_data}.
  - Set cmd_rdy.
  - Pulse clr_rx_rdy.
  - Go to HIGH_WAIT.
  - Latency: cmd and cmd_rdy are valid the cycle after rx_rdy is sampled high.
- LOW_WAIT, rx_rdy=0:
  - Increment the timeout counter.
  - When the counter reaches TIMEOUT_CYC-1: pulse rx_err, discard high_byte, return to HIGH_WAIT. cmd and cmd_rdy are unchanged.
- Timeout and rx_rdy in the same cycle: rx_rdy wins and the command completes.

cmd and cmd_rdy rules:
- cmd holds its value until the next complete command; a partial command never changes it.
- cmd_rdy clears on clr_cmd_rdy.
- Set and clear in the same cycle: set wins.
- A new command completing while cmd_rdy is still 1 overwrites cmd, and cmd_rdy stays 1 (no overrun flag).

TX path (independent of RX, full duplex):
- busy flag. send_resp while busy=0:
  - Pulse UART trmt with tx_data=resp in the same cycle.
  - Set busy.
  - Clear resp_sent.
- UART tx_done sets resp_sent and clears busy.
- send_resp while busy=1 is ignored: no trmt, and resp_sent is unaffected.
- resp is sampled only in the send_resp cycle. The UART buffers it, so resp may change afterwards.

Reset mid-operation:
- All flags clear, the RX state machine returns to HIGH_WAIT, and any partially received high byte is lost.
- The UART is reset by the same rst_n, so any TX frame in flight is aborted and TX returns to 1.

Decomposition:
- Shared package:
  - rx_state_t enum {HIGH_WAIT, LOW_WAIT}.
  - Default timeout constant.
  - Baud-related constants already used by the UART.
- Sub-module: instantiate the existing 8-bit UART transceiver, named UART with ports tx_data, trmt, tx_done, rx_data, rx_rdy, clr_rx_rdy. Do not duplicate it.
- The byte-assembly state machine, timeout counter, busy flag and the two set/reset flags live in this module.

Test Plan:
- Host sends bytes 8'hA5 then 8'h5A.
  - Required: cmd_rdy rises one cycle after the second rx_rdy, cmd=16'hA55A.
  - clr_cmd_rdy pulse then drops cmd_rdy to 0 while cmd stays 16'hA55A.
- TIMEOUT_CYC=1000. Send 8'h12 only, wait 1200 cycles, then send 8'h34, 8'h56.
  - Required: one rx_err pulse about 1000 cycles after the 8'h12 rx_rdy.
  - Required: no cmd_rdy for 8'h12, final cmd=16'h3456.
- Two back-to-back commands, 16'h1111 then 16'h2222, with no clr_cmd_rdy.
  - Required: cmd_rdy stays 1 throughout and final cmd=16'h2222.
  - Also pulse clr_cmd_rdy in the same cycle the second command completes; cmd_rdy must stay 1.
- resp=8'hC3 with a send_resp pulse.
  - Required: TX carries a start bit, LSB-first 1,1,0,0,0,0,1,1, and a stop bit.
  - Required: resp_sent goes 0 then 1 at tx_done.
  - A second send_resp mid-frame produces no extra frame.
- Assert rst_n low after the high byte 8'hFF has been received. Release rst_n, then send 8'h00, 8'h01.
  - Required: all outputs at their reset values during reset.
  - Required: after release, cmd=16'h0001, with no alignment slip from the discarded high byte.
